// File: rtl/gray_pointer_if.sv
// Pointer-controller port bundle: request and remote pointer in, address,
// exported pointer, flags and level out.
interface gray_pointer_if #(
  parameter int ADDRESS_SIZE = 4
);
  logic                    inc;
  logic [ADDRESS_SIZE:0]   remote_gray_pointer;
  logic [ADDRESS_SIZE-1:0] binary_address;
  logic [ADDRESS_SIZE:0]   gray_pointer;
  logic [ADDRESS_SIZE:0]   gray_pointer_next;
  logic                    status_flag;
  logic                    almost_flag;
  logic [ADDRESS_SIZE:0]   fill_level;
  logic                    reject_pulse;

  modport master (
    output inc, remote_gray_pointer,
    input  binary_address, gray_pointer, gray_pointer_next,
           status_flag, almost_flag, fill_level, reject_pulse
  );

  modport slave (
    input  inc, remote_gray_pointer,
    output binary_address, gray_pointer, gray_pointer_next,
           status_flag, almost_flag, fill_level, reject_pulse
  );
endinterface

// File: rtl/gray_pointer_controller.sv
// Async-FIFO pointer controller: binary/gray pointer, remote pointer
// synchroniser and full (write side) or empty (read side) flag generation.
module gray_pointer_controller #(
  parameter int ADDRESS_SIZE     = 4,
  parameter int SYNC_STAGES      = 2,
  parameter int WRITE_SIDE       = 1,
  parameter int ALMOST_THRESHOLD = 2
) (
  input  logic           clk,
  input  logic           reset,
  gray_pointer_if.slave  bus
);
  localparam int PW    = ADDRESS_SIZE + 1;
  localparam int DEPTH = 1 << ADDRESS_SIZE;

  logic [PW-1:0] bin_q, bin_d;
  logic [PW-1:0] gray_q, gray_d;
  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] sync_d [SYNC_STAGES];
  logic          status_q, status_d;
  logic          reject_q, reject_d;

  logic          accept;
  logic [PW-1:0] bin_next;
  logic [PW-1:0] gray_next;
  logic [PW-1:0] sync_gray;
  logic [PW-1:0] rbin;
  logic [PW-1:0] fill;
  logic          almost;
  logic          flag_hit;

  always_comb begin
    accept    = bus.inc & ~status_q;
    bin_next  = bin_q + {{ADDRESS_SIZE{1'b0}}, accept};
    gray_next = bin_next ^ (bin_next >> 1);
    sync_gray = sync_q[SYNC_STAGES-1];

    rbin = '0;
    for (int i = 0; i < PW; i++) rbin[i] = ^(sync_gray >> i);

    // Full when the pointers differ by exactly DEPTH: in gray that is the
    // top two bits inverted, the rest equal.
    if (WRITE_SIDE != 0) begin
      flag_hit = (gray_next == {~sync_gray[PW-1:PW-2], sync_gray[PW-3:0]});
      fill     = bin_q - rbin;
      almost   = (fill >= PW'(DEPTH - ALMOST_THRESHOLD));
    end else begin
      flag_hit = (gray_next == sync_gray);
      fill     = rbin - bin_q;
      almost   = (fill <= PW'(ALMOST_THRESHOLD));
    end
  end

  always_comb begin
    bin_d    = bin_next;
    gray_d   = gray_next;
    status_d = flag_hit;
    reject_d = bus.inc & status_q;
    sync_d[0] = bus.remote_gray_pointer;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];

    if (reset) begin
      bin_d    = '0;
      gray_d   = '0;
      status_d = (WRITE_SIDE == 0);
      reject_d = 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_d[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    bin_q    <= bin_d;
    gray_q   <= gray_d;
    status_q <= status_d;
    reject_q <= reject_d;
    for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
  end

  assign bus.binary_address    = bin_q[ADDRESS_SIZE-1:0];
  assign bus.gray_pointer      = gray_q;
  assign bus.gray_pointer_next = gray_next;
  assign bus.status_flag       = status_q;
  assign bus.almost_flag       = almost;
  assign bus.fill_level        = fill;
  assign bus.reject_pulse      = reject_q;
endmodule

// File: tb/tb_gray_pointer_controller.sv
// Bench for gray_pointer_controller: write-side and read-side instances
// against an arithmetic pointer-distance model, directed cases then random.
module tb_gray_pointer_controller;
  localparam int AS    = 4;
  localparam int SS    = 2;
  localparam int TH    = 2;
  localparam int DEPTH = 16;
  localparam int MSK   = 31;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gray_pointer_if #(.ADDRESS_SIZE(AS)) wif ();
  gray_pointer_if #(.ADDRESS_SIZE(AS)) rif ();

  gray_pointer_controller #(.ADDRESS_SIZE(AS), .SYNC_STAGES(SS), .WRITE_SIDE(1),
                            .ALMOST_THRESHOLD(TH))
    u_wr (.clk(clk), .reset(reset), .bus(wif));

  gray_pointer_controller #(.ADDRESS_SIZE(AS), .SYNC_STAGES(SS), .WRITE_SIDE(0),
                            .ALMOST_THRESHOLD(TH))
    u_rd (.clk(clk), .reset(reset), .bus(rif));

  int n_chk = 0;
  int n_err = 0;

  // model state, index 1 = write side, 0 = read side; pointers held in binary
  int   m_bin  [2];
  int   m_stat [2];
  int   m_rej  [2];
  int   m_sync [2][SS];
  int   rem    [2];
  logic inc_s  [2];

  function automatic int gray(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int m_fill(input int s);
    if (s == 1) return (m_bin[s] - m_sync[s][SS-1]) & MSK;
    return (m_sync[s][SS-1] - m_bin[s]) & MSK;
  endfunction

  function automatic int m_almost(input int s);
    if (s == 1) return (m_fill(s) >= DEPTH - TH) ? 1 : 0;
    return (m_fill(s) <= TH) ? 1 : 0;
  endfunction

  task automatic check_side(input int s, input logic [31:0] a, input logic [31:0] g,
                            input logic [31:0] gn, input logic [31:0] st,
                            input logic [31:0] al, input logic [31:0] fl,
                            input logic [31:0] rj);
    string p;
    int    acc;
    p   = (s == 1) ? "w" : "r";
    acc = (inc_s[s] && m_stat[s] == 0) ? 1 : 0;
    chk({p, "_addr"},   a,  m_bin[s] % DEPTH);
    chk({p, "_gray"},   g,  gray(m_bin[s]));
    chk({p, "_gnext"},  gn, gray((m_bin[s] + acc) & MSK));
    chk({p, "_status"}, st, m_stat[s]);
    chk({p, "_almost"}, al, m_almost(s));
    chk({p, "_fill"},   fl, m_fill(s));
    chk({p, "_reject"}, rj, m_rej[s]);
  endtask

  task automatic model_edge();
    for (int s = 0; s < 2; s++) begin
      if (reset) begin
        m_bin[s]  = 0;
        m_rej[s]  = 0;
        m_stat[s] = (s == 1) ? 0 : 1;
        for (int k = 0; k < SS; k++) m_sync[s][k] = 0;
      end else begin
        int old_st, nb, rs;
        old_st = m_stat[s];
        nb     = (m_bin[s] + ((inc_s[s] && old_st == 0) ? 1 : 0)) & MSK;
        rs     = m_sync[s][SS-1];
        if (s == 1) m_stat[s] = (((nb - rs) & MSK) == DEPTH) ? 1 : 0;
        else        m_stat[s] = (nb == rs) ? 1 : 0;
        m_rej[s] = (inc_s[s] && old_st != 0) ? 1 : 0;
        m_bin[s] = nb;
        for (int k = SS-1; k > 0; k--) m_sync[s][k] = m_sync[s][k-1];
        m_sync[s][0] = rem[s];
      end
    end
  endtask

  task automatic cycle(input logic rst, input logic iw, input int rw,
                       input logic ir, input int rr);
    reset    = rst;
    inc_s[1] = iw;
    inc_s[0] = ir;
    rem[1]   = rw & MSK;
    rem[0]   = rr & MSK;
    wif.inc  = iw;
    rif.inc  = ir;
    wif.remote_gray_pointer = 5'(gray(rem[1]));
    rif.remote_gray_pointer = 5'(gray(rem[0]));
    #1;
    check_side(1, 32'(wif.binary_address), 32'(wif.gray_pointer), 32'(wif.gray_pointer_next),
               32'(wif.status_flag), 32'(wif.almost_flag), 32'(wif.fill_level),
               32'(wif.reject_pulse));
    check_side(0, 32'(rif.binary_address), 32'(rif.gray_pointer), 32'(rif.gray_pointer_next),
               32'(rif.status_flag), 32'(rif.almost_flag), 32'(rif.fill_level),
               32'(rif.reject_pulse));
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic wr(input logic iw, input int rw);
    cycle(1'b0, iw, rw, 1'b0, rem[0]);
  endtask

  task automatic rd(input logic ir, input int rr);
    cycle(1'b0, 1'b0, rem[1], ir, rr);
  endtask

  task automatic rst_cyc(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 0, 1'b0, 0);
  endtask

  initial begin
    int gseq [5];
    int full_seen;
    int rw_b, rr_b;
    gseq = '{0, 1, 3, 2, 6};

    for (int s = 0; s < 2; s++) begin
      m_bin[s] = 0; m_stat[s] = (s == 1) ? 0 : 1; m_rej[s] = 0;
      rem[s] = 0; inc_s[s] = 1'b0;
      for (int k = 0; k < SS; k++) m_sync[s][k] = 0;
    end
    reset = 1'b1;
    wif.inc = 1'b0; rif.inc = 1'b0;
    wif.remote_gray_pointer = '0; rif.remote_gray_pointer = '0;
    @(posedge clk);
    @(negedge clk);
    rst_cyc(2);
    wif.inc = 1'b0; rif.inc = 1'b0;

    // reset values
    chk("rst_w_status", 32'(wif.status_flag), 0);
    chk("rst_r_status", 32'(rif.status_flag), 1);
    chk("rst_w_almost", 32'(wif.almost_flag), 0);
    chk("rst_r_almost", 32'(rif.almost_flag), 1);
    chk("rst_w_fill",   32'(wif.fill_level), 0);
    chk("rst_w_gnext",  32'(wif.gray_pointer_next), 0);

    // fill to full with a stationary reader
    for (int i = 0; i < 17; i++) begin
      wr(1'b1, 0);
      if (i < 4)   chk("fill_gray_seq", 32'(wif.gray_pointer), gseq[i+1]);
      if (i == 14) chk("fill_not_full", 32'(wif.status_flag), 0);
      if (i == 15) begin
        chk("fill_full",  32'(wif.status_flag), 1);
        chk("fill_lvl16", 32'(wif.fill_level), 16);
      end
    end
    chk("full_reject",     32'(wif.reject_pulse), 1);
    chk("full_gray_hold",  32'(wif.gray_pointer), 24);
    chk("full_addr",       32'(wif.binary_address), 0);
    wr(1'b0, 0);
    chk("reject_one_cycle", 32'(wif.reject_pulse), 0);

    // almost-full threshold
    rst_cyc(1);
    for (int i = 0; i < 13; i++) wr(1'b1, 0);
    chk("almost_13_fill", 32'(wif.fill_level), 13);
    chk("almost_13_flag", 32'(wif.almost_flag), 0);
    wr(1'b1, 0);
    chk("almost_14_fill", 32'(wif.fill_level), 14);
    chk("almost_14_flag", 32'(wif.almost_flag), 1);

    // reader tracking the writer: full wrap without full
    rst_cyc(1);
    full_seen = 0;
    for (int i = 0; i < 32; i++) begin
      wr(1'b1, m_bin[1]);
      if (wif.status_flag) full_seen = 1;
      if (i == 14) chk("wrap_addr15", 32'(wif.binary_address), 15);
      if (i == 15) chk("wrap_addr0",  32'(wif.binary_address), 0);
      if (i == 30) chk("wrap_gray31", 32'(wif.gray_pointer), 16);
      if (i == 31) chk("wrap_gray0",  32'(wif.gray_pointer), 0);
    end
    chk("wrap_never_full", full_seen, 0);

    // reset in mid-operation with inc held
    rst_cyc(1);
    for (int i = 0; i < 5; i++) wr(1'b1, 0);
    cycle(1'b1, 1'b1, 0, 1'b0, 0);
    chk("mrst_addr",   32'(wif.binary_address), 0);
    chk("mrst_gray",   32'(wif.gray_pointer), 0);
    chk("mrst_fill",   32'(wif.fill_level), 0);
    chk("mrst_almost", 32'(wif.almost_flag), 0);
    chk("mrst_reject", 32'(wif.reject_pulse), 0);
    reset = 1'b0; wif.inc = 1'b0; inc_s[1] = 1'b0;
    #1;
    chk("mrst_gnext", 32'(wif.gray_pointer_next), 0);
    wr(1'b1, 0);
    chk("mrst_first_write", 32'(wif.gray_pointer), 1);

    // read side: three entries arrive, then drained
    rst_cyc(1);
    rd(1'b0, 3);
    rd(1'b0, 3);
    chk("rd_fill3",      32'(rif.fill_level), 3);
    chk("rd_still_empty", 32'(rif.status_flag), 1);
    rd(1'b0, 3);
    chk("rd_not_empty",  32'(rif.status_flag), 0);
    rd(1'b1, 3);
    chk("rd_1_status",   32'(rif.status_flag), 0);
    rd(1'b1, 3);
    chk("rd_2_status",   32'(rif.status_flag), 0);
    rd(1'b1, 3);
    chk("rd_3_empty",    32'(rif.status_flag), 1);
    chk("rd_3_addr",     32'(rif.binary_address), 3);

    // full, reader advances by one while writes are held
    rst_cyc(1);
    for (int i = 0; i < 16; i++) wr(1'b1, 0);
    wr(1'b1, 1);
    chk("rel_e1_full", 32'(wif.status_flag), 1);
    wr(1'b1, 1);
    chk("rel_e2_full", 32'(wif.status_flag), 1);
    wr(1'b1, 1);
    chk("rel_e3_free",   32'(wif.status_flag), 0);
    chk("rel_e3_reject", 32'(wif.reject_pulse), 1);
    chk("rel_e3_gray",   32'(wif.gray_pointer), 24);
    wr(1'b1, 1);
    chk("rel_e4_gray",   32'(wif.gray_pointer), 25);
    chk("rel_e4_full",   32'(wif.status_flag), 1);
    chk("rel_e4_reject", 32'(wif.reject_pulse), 0);

    // random traffic; remote pointers never overtake / overrun
    rst_cyc(1);
    rw_b = 0; rr_b = 0;
    for (int i = 0; i < 3000; i++) begin
      logic rst_r, iw, ir;
      rst_r = ($urandom_range(0, 199) == 0);
      iw    = $urandom_range(0, 2) != 0;
      ir    = $urandom_range(0, 2) != 0;
      if (rst_r) begin
        rw_b = 0; rr_b = 0;
      end else begin
        if ($urandom_range(0, 2) == 0 && ((m_bin[1] - rw_b) & MSK) != 0) rw_b = (rw_b + 1) & MSK;
        if ($urandom_range(0, 1) == 0 && ((rr_b - m_bin[0]) & MSK) < DEPTH) rr_b = (rr_b + 1) & MSK;
      end
      cycle(rst_r, iw, rw_b, ir, rr_b);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/gray_pointer_controller.md
GRAY_POINTER_CONTROLLER -- requirements
Module: gray_pointer_controller

Interface
REQ-001 The block SHALL have parameter ADDRESS_SIZE, default 4: memory address width; FIFO depth DEPTH = 2**ADDRESS_SIZE; legal range >= 2.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2: flop count of the remote-pointer synchroniser; legal range >= 2.
REQ-003 The block SHALL have parameter WRITE_SIDE, default 1: 1 = write-side controller (full logic); 0 = read-side controller (empty logic).
REQ-004 The block SHALL have parameter ALMOST_THRESHOLD, default 2: almost-flag margin; legal range 1..DEPTH-1.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port inc, input, 1 bit: write_enable or read_enable request.
REQ-008 The block SHALL have port remote_gray_pointer, input, ADDRESS_SIZE+1 bits: gray pointer from the opposite domain; asynchronous to clk.
REQ-009 The block SHALL have port binary_address, output, ADDRESS_SIZE bits: memory address.
REQ-010 The block SHALL have port gray_pointer, output, ADDRESS_SIZE+1 bits: registered gray pointer exported to the opposite domain.
REQ-011 The block SHALL have port gray_pointer_next, output, ADDRESS_SIZE+1 bits: gray value the pointer loads at the next edge.
REQ-012 The block SHALL have port status_flag, output, 1 bit: full (WRITE_SIDE=1) or empty (WRITE_SIDE=0), registered.
REQ-013 The block SHALL have port almost_flag, output, 1 bit: almost-full or almost-empty indication.
REQ-014 The block SHALL have port fill_level, output, ADDRESS_SIZE+1 bits: occupancy (write side) or available entries (read side), range 0..DEPTH.
REQ-015 The block SHALL have port reject_pulse, output, 1 bit: one-cycle pulse marking a blocked request.

Function
REQ-016 Accepted increment SHALL be accept = inc & ~status_flag.
REQ-017 An internal binary count bin (ADDRESS_SIZE+1 bits) SHALL load bin_next = bin + accept each edge, wrapping modulo 2**(ADDRESS_SIZE+1).
REQ-018 gray_pointer_next SHALL equal bin_next ^ (bin_next >> 1), combinationally; gray_pointer SHALL register gray_pointer_next each edge.
REQ-019 binary_address SHALL equal bin[ADDRESS_SIZE-1:0], wrapping DEPTH-1 -> 0.
REQ-020 remote_gray_pointer SHALL pass through a SYNC_STAGES-deep flop chain; sync_gray = last stage; no logic between stages.
REQ-021 sync_gray SHALL be converted gray-to-binary (rbin) combinationally after the final stage.
REQ-022 If WRITE_SIDE=1, status_flag SHALL load (gray_pointer_next == {~sync_gray[ADDRESS_SIZE:ADDRESS_SIZE-1], sync_gray[ADDRESS_SIZE-2:0]}) each edge.
REQ-023 If WRITE_SIDE=0, status_flag SHALL load (gray_pointer_next == sync_gray) each edge.
REQ-024 fill_level SHALL be bin - rbin (WRITE_SIDE=1) or rbin - bin (WRITE_SIDE=0), modulo 2**(ADDRESS_SIZE+1), derived only from registered state.
REQ-025 almost_flag SHALL be (fill_level >= DEPTH - ALMOST_THRESHOLD) on the write side and (fill_level <= ALMOST_THRESHOLD) on the read side.
REQ-026 reject_pulse SHALL register inc & status_flag, i.e. assert exactly one cycle after each blocked request.
REQ-027 A request in a cycle where status_flag is high SHALL be rejected even if the remote pointer releases the flag at the same edge.
REQ-028 bin SHALL never advance while status_flag is high.
REQ-029 Flag release by remote pointer movement SHALL occur no earlier than SYNC_STAGES+1 edges after the remote change.

Reset
REQ-030 While reset is high at an edge, bin, gray_pointer, all sync stages and reject_pulse SHALL clear to 0.
REQ-031 While reset is high at an edge, status_flag SHALL load 0 if WRITE_SIDE=1 and 1 if WRITE_SIDE=0.
REQ-032 Reset asserted mid-operation SHALL discard all state within one edge with no partial update; inc during reset SHALL be ignored.
REQ-033 After reset, binary_address=0, gray_pointer_next=0, fill_level=0, and almost_flag=0 (write side) or 1 (read side).

Verification
REQ-034 The bench SHALL cover: write side, remote=0, inc held 17 cycles -> gray_pointer 00000,00001,00011,00010,00110...; status_flag=1 at the edge bin reaches 16; fill_level=16; 17th request rejected; reject_pulse one cycle; binary_address stays 0.
REQ-035 The bench SHALL cover: read side, remote set to 00010 (3 entries) -> fill_level=3 after 2 edges; status_flag falls at edge 3; three reads -> status_flag=1 at the third read edge; binary_address=3.
REQ-036 The bench SHALL cover: write side, remote tracking own pointer, 32 writes -> bin wraps 31->0, gray 10000->00000, binary_address wraps 15->0, status_flag never asserted.
REQ-037 The bench SHALL cover: write side, 14 writes with remote=0 -> fill_level=14, almost_flag=1; after 13 writes almost_flag=0.
REQ-038 The bench SHALL cover: 5 writes, then one-cycle reset with inc high -> all outputs at REQ-033 values next cycle; following inc accepted, gray_pointer=00001.
REQ-039 The bench SHALL cover: write side full, remote advances by 1 while inc held -> inc in the cycle before release rejected, accepted the cycle after status_flag falls.
